// File: rtl/hamming_secded_decoder.sv
// Bit-serial SECDED Hamming(16,11) decoder: scans a captured codeword one bit per
// cycle, then corrects single errors / flags double errors and counts both kinds.
`timescale 1ns/1ps

module hamming_secded_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      codeword_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      data_out,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] single_cnt,
    output logic [CNT_W-1:0] double_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_SINGLE = 2'b01;
    localparam logic [1:0] ST_DOUBLE = 2'b10;

    logic [1:0]  state;
    logic [15:0] code;
    logic [3:0]  cnt;
    logic [3:0]  syndrome;
    logic        parity;

    logic [15:0] fixed;
    logic [1:0]  verdict;
    logic [10:0] extracted;

    assign in_ready = (state == IDLE);

    // Odd overall parity means exactly one flipped bit; a zero syndrome then points at p0.
    always_comb begin
        fixed   = code;
        verdict = ST_CLEAN;
        if (parity) begin
            verdict = ST_SINGLE;
            if (syndrome != 4'd0)
                fixed = code ^ (16'd1 << syndrome);
        end else if (syndrome != 4'd0) begin
            verdict = ST_DOUBLE;
        end
        extracted = {fixed[15:9], fixed[7:5], fixed[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            code       <= 16'd0;
            cnt        <= 4'd0;
            syndrome   <= 4'd0;
            parity     <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= 11'd0;
            status     <= ST_CLEAN;
            single_cnt <= '0;
            double_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code     <= codeword_in;
                        cnt      <= 4'd0;
                        syndrome <= 4'd0;
                        parity   <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (code[cnt]) begin
                        parity   <= ~parity;
                        syndrome <= syndrome ^ cnt;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= CHECK;
                end
                CHECK: begin
                    data_out  <= extracted;
                    status    <= verdict;
                    out_valid <= 1'b1;
                    // Counters move once per decoded word and stick at all-ones.
                    if (verdict == ST_SINGLE && single_cnt != '1)
                        single_cnt <= single_cnt + CNT_W'(1);
                    if (verdict == ST_DOUBLE && double_cnt != '1)
                        double_cnt <= double_cnt + CNT_W'(1);
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized bench for hamming_secded_decoder: a position-table decoding model and
// saturating counter model checked every cycle, plus directed literal cases.
`timescale 1ns/1ps

module tb_hamming_secded_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] codeword_in;

    logic        in_ready, out_valid;
    logic [10:0] data_out;
    logic [1:0]  status;
    logic [7:0]  single_cnt, double_cnt;

    logic        in_ready2, out_valid2;
    logic [10:0] data_out2;
    logic [1:0]  status2;
    logic [1:0]  single_cnt2, double_cnt2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    hamming_secded_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .status(status),
        .single_cnt(single_cnt), .double_cnt(double_cnt)
    );

    // Narrow-counter copy driven identically, used to observe saturation.
    hamming_secded_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .codeword_in(codeword_in), .out_valid(out_valid2), .out_ready(out_ready),
        .data_out(data_out2), .status(status2),
        .single_cnt(single_cnt2), .double_cnt(double_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [10:0] d;
        logic [1:0]  st;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   pos_tab[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Returns {status, data}: syndrome is the XOR of the positions of all set bits.
    function automatic logic [12:0] model_decode(input logic [15:0] w);
        int          s = 0;
        logic        p = ^w;
        logic [15:0] c = w;
        logic [10:0] d;
        logic [1:0]  st;
        for (int i = 0; i < 16; i++) if (w[i]) s = s ^ i;
        if (s == 0 && !p) st = 2'b00;
        else if (p) begin
            st = 2'b01;
            if (s != 0) c[s] = ~c[s];
        end else st = 2'b10;
        for (int k = 0; k < 11; k++) d[k] = c[pos_tab[k]];
        return {st, d};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w = 16'd0;
        int          s = 0;
        for (int k = 0; k < 11; k++) begin
            w[pos_tab[k]] = d[k];
            if (d[k]) s = s ^ pos_tab[k];
        end
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[8] = s[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    int   sm = 0, dm = 0, sm2 = 0, dm2 = 0;
    logic armed = 1'b0, seen = 1'b0, hs_pending = 1'b0, post_reset = 1'b0;
    logic [10:0] cur_d;
    logic [1:0]  cur_st;
    logic [12:0] r;

    // Single compare process; accept-to-visible distance is 18 in negedge cycle stamps (17 edges).
    always @(negedge clk) begin
        if (!armed) begin
            if (reset) armed = 1'b1;
        end else begin
            if (post_reset) begin
                check("rst_in_ready", in_ready, 1);
                check("rst_out_valid", out_valid, 0);
                check("rst_data_out", data_out, 0);
                check("rst_status", status, 0);
                post_reset = 1'b0;
            end
            if (hs_pending) begin
                check("hs_out_valid", out_valid, 0);
                check("hs_in_ready", in_ready, 1);
                hs_pending = 1'b0;
            end
            if (out_valid && !seen) begin
                if (q.size() == 0) fail("spurious_out_valid");
                else begin
                    e = q.pop_front();
                    if (e.st == 2'b01) begin
                        sm  = (sm == 255) ? 255 : sm + 1;
                        sm2 = (sm2 == 3) ? 3 : sm2 + 1;
                    end
                    if (e.st == 2'b10) begin
                        dm  = (dm == 255) ? 255 : dm + 1;
                        dm2 = (dm2 == 3) ? 3 : dm2 + 1;
                    end
                    check("data_out", data_out, e.d);
                    check("status", status, e.st);
                    check("latency", cyc - e.acc, 18);
                    check("sat_out_valid", out_valid2, 1);
                    check("sat_data_out", data_out2, e.d);
                    check("sat_status", status2, e.st);
                    cur_d  = e.d;
                    cur_st = e.st;
                end
                seen = 1'b1;
            end else if (out_valid) begin
                check("hold_data_out", data_out, cur_d);
                check("hold_status", status, cur_st);
            end
            if (out_valid) check("busy_in_ready", in_ready, 0);
            else begin
                seen = 1'b0;
                check("idle_in_ready", in_ready, (q.size() == 0) ? 1 : 0);
                if (q.size() > 0 && cyc - q[0].acc > 18) begin
                    fail("out_valid_timeout");
                    void'(q.pop_front());
                end
            end
            check("single_cnt", single_cnt, sm);
            check("double_cnt", double_cnt, dm);
            check("sat_single_cnt", single_cnt2, sm2);
            check("sat_double_cnt", double_cnt2, dm2);
            if (out_valid && out_ready) hs_pending = 1'b1;
            if (in_valid && in_ready) begin
                r    = model_decode(codeword_in);
                e.d  = r[10:0];
                e.st = r[12:11];
                e.acc = cyc;
                q.push_back(e);
            end
            if (reset) begin
                q.delete();
                sm = 0; dm = 0; sm2 = 0; dm2 = 0;
                seen = 1'b0;
                hs_pending = 1'b0;
                post_reset = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] w, input int stall);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) fail("in_ready_timeout");
        out_ready   = (stall == 0);
        in_valid    = 1'b1;
        codeword_in = w;
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid    = 1'($urandom_range(0, 1));
            codeword_in = 16'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!out_valid) fail("wait_out_valid_timeout");
    endtask

    task automatic releaseOutput(input int stall);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic checkOutput(input logic [10:0] d, input logic [1:0] s,
                               input int sc, input int dc, input int sc2);
        check("lit_data_out", data_out, d);
        check("lit_status", status, s);
        if (sc >= 0)  check("lit_single_cnt", single_cnt, sc);
        if (dc >= 0)  check("lit_double_cnt", double_cnt, dc);
        if (sc2 >= 0) check("lit_sat_single_cnt", single_cnt2, sc2);
    endtask

    logic [15:0] w;
    int          b0, b1, nflip, stall;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; codeword_in = 16'd0;

        check("model_pin_ffd7", model_decode(16'hFFD7), {2'b10, 11'h7FC});
        check("model_pin_1000", model_decode(16'h1000), {2'b01, 11'h000});
        check("encode_pin_7ff", encode(11'h7FF), 16'hFFFF);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus(16'h0000, 0); checkOutput(11'h000, 2'b00, 0, 0, -1); releaseOutput(0);
        applyStimulus(16'hFFFF, 0); checkOutput(11'h7FF, 2'b00, 0, 0, -1); releaseOutput(0);
        applyStimulus(16'hFFBF, 0); checkOutput(11'h7FF, 2'b01, 1, 0, -1); releaseOutput(0);
        applyStimulus(16'h1000, 0); checkOutput(11'h000, 2'b01, 2, 0, -1); releaseOutput(0);
        applyStimulus(16'hFFFE, 0); checkOutput(11'h7FF, 2'b01, 3, 0, -1); releaseOutput(0);
        applyStimulus(16'hFFD7, 10); checkOutput(11'h7FC, 2'b10, 3, 1, -1); releaseOutput(10);

        // Reset during the scan must discard the word and leave no output behind.
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1; codeword_in = 16'hFFBF;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        applyStimulus(16'h0000, 0); checkOutput(11'h000, 2'b00, 0, 0, 0); releaseOutput(0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'hFFBF, 0);
            checkOutput(11'h7FF, 2'b01, i + 1, 0, (i < 3) ? i + 1 : 3);
            releaseOutput(0);
        end

        for (int i = 0; i < 40; i++) begin
            w     = encode(11'($urandom));
            nflip = $urandom_range(0, 2);
            b0    = $urandom_range(0, 15);
            b1    = (b0 + $urandom_range(1, 15)) % 16;
            if (nflip >= 1) w[b0] = ~w[b0];
            if (nflip == 2) w[b1] = ~w[b1];
            stall = $urandom_range(0, 3);
            applyStimulus(w, stall);
            releaseOutput(stall);
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
